cfa_stream_sequencer: RTL

- Frame-timing controller that drives the vsync/hsync/den/raw input of the cfa demosaic stage.
- Pulls 8-bit Bayer pixels from an upstream FIFO using a valid/ready handshake.
- Generates the frame envelope the demosaic stage expects: vsync high for the whole frame, hsync = den high only during active pixels, and a gap between lines so the line counter advances on each hsync rising edge.
- Supports single-shot or continuous frames, reports status, and flags underflow when the FIFO runs dry mid-line.

---
 rtl/cfa_stream_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/cfa_stream_sequencer.sv
// Frame-timing controller feeding the cfa demosaic stage: pulls raw Bayer pixels
// from an upstream FIFO and wraps them in the vsync/hsync/den frame envelope.
module cfa_stream_sequencer #(
  parameter int H_ACTIVE = 512,
  parameter int V_ACTIVE = 512,
  parameter int H_BLANK  = 16,
  parameter int V_PRE    = 8,
  parameter int V_BLANK  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        continuous,
  input  logic        stop,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic        out_vsync,
  output logic        out_hsync,
  output logic        out_den,
  output logic [7:0]  out_raw,
  output logic        busy,
  output logic        frame_done,
  output logic        underflow,
  output logic [11:0] line_cnt,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VPRE,
    S_ACTIVE,
    S_HBLANK,
    S_VBLANK
  } state_t;

  localparam logic [15:0] VPRE_LAST   = 16'(V_PRE - 1);
  localparam logic [15:0] HACT_LAST   = 16'(H_ACTIVE - 1);
  localparam logic [15:0] HBLANK_LAST = 16'(H_BLANK - 1);
  localparam logic [15:0] VBLANK_LAST = 16'(V_BLANK - 1);
  localparam logic [11:0] LINE_LAST   = 12'(V_ACTIVE - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        cont_latch;
  logic        cnt_last;

  // Timing never stalls: the cfa stage derives its X position from hsync, so a
  // pixel slot is consumed every ACTIVE cycle whether or not data is there.
  assign pix_ready = (state == S_ACTIVE);

  always_comb begin
    cnt_last = 1'b0;
    unique case (state)
      S_VPRE:   cnt_last = (cnt == VPRE_LAST);
      S_ACTIVE: cnt_last = (cnt == HACT_LAST);
      S_HBLANK: cnt_last = (cnt == HBLANK_LAST);
      S_VBLANK: cnt_last = (cnt == VBLANK_LAST);
      default:  cnt_last = 1'b0;
    endcase
  end

  // NOTE: all state and outputs use non-blocking assignments so every decode
  // below sees the pre-edge state, giving the uniform one-cycle output lag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cont_latch <= 1'b0;
      out_vsync  <= 1'b0;
      out_hsync  <= 1'b0;
      out_den    <= 1'b0;
      out_raw    <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
      line_cnt   <= '0;
      frame_cnt  <= '0;
    end else begin
      out_vsync  <= (state == S_VPRE) || (state == S_ACTIVE) || (state == S_HBLANK);
      out_hsync  <= (state == S_ACTIVE);
      out_den    <= (state == S_ACTIVE);
      out_raw    <= ((state == S_ACTIVE) && pix_valid) ? pix_data : 8'h00;
      busy       <= (state != S_IDLE);
      frame_done <= 1'b0;

      if (stop) cont_latch <= 1'b0;
      if ((state == S_ACTIVE) && !pix_valid) underflow <= 1'b1;

      if (state != S_IDLE) cnt <= cnt_last ? 16'd0 : cnt + 16'd1;

      unique case (state)
        S_IDLE: begin
          // busy still reads 1 during the frame_done cycle, so a start there is ignored
          if (start && !busy) begin
            state      <= S_VPRE;
            cnt        <= '0;
            cont_latch <= continuous & ~stop;
            underflow  <= 1'b0;
            line_cnt   <= '0;
          end
        end
        S_VPRE: begin
          if (cnt_last) state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (cnt_last) state <= S_HBLANK;
        end
        S_HBLANK: begin
          if (cnt_last) begin
            if (line_cnt == LINE_LAST) begin
              state <= S_VBLANK;
            end else begin
              line_cnt <= line_cnt + 12'd1;
              state    <= S_ACTIVE;
            end
          end
        end
        S_VBLANK: begin
          if (cnt_last) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
            if (cont_latch && !stop) begin
              state    <= S_VPRE;
              line_cnt <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
